// File: rtl/ram_dp_be.sv
// Dual-port byte-enable RAM: port A read/write (read-first), port B read-only with A->B write forwarding.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); reset optionally zero-fills all MEM_SIZE words.
// Backpressure: none; both ports accept a request every cycle, but all requests are dropped while busy.
module ram_dp_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES     = DATA_WIDTH / 8,
  localparam int MEM_SIZE      = 1 << ADDR_WIDTH
) (
  input  logic                  clka,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  ena,
  input  logic [NUM_BYTES-1:0]  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  douta_valid,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // With clearing disabled, reset lands straight in RUN so busy never rises.
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  // First output stage: the registered read data and strobes.
  logic [DATA_WIDTH-1:0] douta1_q, douta1_d;
  logic [DATA_WIDTH-1:0] doutb1_q, doutb1_d;
  logic                  va1_q, va1_d;
  logic                  vb1_q, vb1_d;

  // Shared write port: either the clear engine or port A owns it.
  logic [NUM_BYTES-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdat;

  logic                  a_req;
  logic                  b_req;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rda;
  logic [DATA_WIDTH-1:0] rdb;

  assign busy = (state_q == CLEAR);

  // Clear-engine sequencing: walk every address once, then hand over to RUN.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      if (clr_addr_q == CLR_LAST) begin
        state_d = RUN;
      end
    end
  end

  // Write-port arbitration; requests during reset or clearing never touch memory.
  always_comb begin
    mem_we    = '0;
    mem_waddr = addra;
    mem_wdat  = dina;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = '1;
        mem_waddr = clr_addr_q;
        mem_wdat  = '0;
      end else if (ena) begin
        mem_we = wea;
      end
    end
  end

  // Read paths: A sees the pre-write word, B sees bytes A writes this cycle to the same address.
  always_comb begin
    a_req   = ena && (state_q == RUN);
    b_req   = enb && (state_q == RUN);
    collide = a_req && (wea != '0) && (addra == addrb);
    rda     = mem[addra];
    rdb     = mem[addrb];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (collide && wea[i]) begin
        rdb[i*8 +: 8] = dina[i*8 +: 8];
      end
    end
    douta1_d = a_req ? rda : douta1_q;
    doutb1_d = b_req ? rdb : doutb1_q;
    va1_d    = a_req;
    vb1_d    = b_req;
  end

  // Byte-lane memory write.
  always_ff @(posedge clka) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mem_we[i]) begin
        mem[mem_waddr][i*8 +: 8] <= mem_wdat[i*8 +: 8];
      end
    end
  end

  // Control and first-stage registers; reset also kills any read in flight.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
      douta1_q   <= '0;
      doutb1_q   <= '0;
      va1_q      <= 1'b0;
      vb1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      douta1_q   <= douta1_d;
      doutb1_q   <= doutb1_d;
      va1_q      <= va1_d;
      vb1_q      <= vb1_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] douta2_q, douta2_d;
    logic [DATA_WIDTH-1:0] doutb2_q, doutb2_d;
    logic                  va2_q, va2_d;
    logic                  vb2_q, vb2_d;

    // Second stage simply retimes stage one; stage one already holds between reads.
    always_comb begin
      douta2_d = douta1_q;
      doutb2_d = doutb1_q;
      va2_d    = va1_q;
      vb2_d    = vb1_q;
    end

    // Output register stage.
    always_ff @(posedge clka) begin
      if (rst) begin
        douta2_q <= '0;
        doutb2_q <= '0;
        va2_q    <= 1'b0;
        vb2_q    <= 1'b0;
      end else begin
        douta2_q <= douta2_d;
        doutb2_q <= doutb2_d;
        va2_q    <= va2_d;
        vb2_q    <= vb2_d;
      end
    end

    assign douta       = douta2_q;
    assign doutb       = doutb2_q;
    assign douta_valid = va2_q;
    assign doutb_valid = vb2_q;
  end else begin : g_noreg
    assign douta       = douta1_q;
    assign doutb       = doutb1_q;
    assign douta_valid = va1_q;
    assign doutb_valid = vb1_q;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: three instances (32b/16w 1-cycle, 32b/16w 2-cycle, 64b/1024w no-clear).
// Latency: the two narrow instances share stimulus so their outputs can be compared at t+1 and t+2.
// Backpressure: none in the DUT; every wait on busy is bounded by a cycle budget.
module tb_ram_dp_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared stimulus for the two narrow instances.
  logic        rst, ena, enb;
  logic [3:0]  wea, addra, addrb;
  logic [31:0] dina;
  logic        busy0, dva0, dvb0, busy1, dva1, dvb1;
  logic [31:0] douta0, doutb0, douta1, doutb1;

  // Wide instance.
  logic        rst2, ena2, enb2;
  logic [7:0]  wea2;
  logic [9:0]  addra2, addrb2;
  logic [63:0] dina2, douta2, doutb2;
  logic        busy2, dva2, dvb2;

  int   n;
  logic seen;

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clka(clk), .rst(rst), .busy(busy0), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta0), .douta_valid(dva0), .enb(enb), .addrb(addrb), .doutb(doutb0), .doutb_valid(dvb0));

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .clka(clk), .rst(rst), .busy(busy1), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta1), .douta_valid(dva1), .enb(enb), .addrb(addrb), .doutb(doutb1), .doutb_valid(dvb1));

  ram_dp_be #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
    .clka(clk), .rst(rst2), .busy(busy2), .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2),
    .douta(douta2), .douta_valid(dva2), .enb(enb2), .addrb(addrb2), .doutb(doutb2), .doutb_valid(dvb2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count busy cycles on the narrow instances and note any strobe seen meanwhile.
  task automatic wait_clear(output int cnt, output logic strobe);
    cnt    = 0;
    strobe = 1'b0;
    while ((busy0 === 1'b1) && (cnt < 200)) begin
      strobe = strobe | dva0 | dvb0 | dva1 | dvb1;
      cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; addra = '0; addrb = '0; dina = '0;
    rst2 = 1'b1; ena2 = 1'b0; enb2 = 1'b0; wea2 = '0; addra2 = '0; addrb2 = '0; dina2 = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_douta0", douta0, 0);
    chk("rst_doutb0", doutb0, 0);
    chk("rst_dva0", dva0, 0);
    chk("rst_dvb1", dvb1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_douta2", douta2, 0);
    rst = 1'b0; rst2 = 1'b0;
    wait_clear(n, seen);
    chk("init_clear_len", 64'(n), 16);
    chk("init_busy1", busy1, 0);

    // Preload all ones, then a reset must zero-fill in exactly 16 cycles
    ena = 1'b1; wea = 4'hF; dina = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      addra = 4'(i);
      tick();
    end
    ena = 1'b0; wea = 4'h0;
    enb = 1'b1; addrb = 4'd9;
    tick();
    enb = 1'b0;
    chk("preload_rd", doutb0, 32'hFFFF_FFFF);
    rst = 1'b1;
    tick();
    chk("clr_busy_after_rst", busy0, 1);
    rst = 1'b0;
    wait_clear(n, seen);
    chk("clr_len", 64'(n), 16);
    chk("clr_no_strobe", 64'(seen), 0);
    enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addrb = 4'(i);
      tick();
      chk("clr_data", doutb0, 0);
      chk("clr_vld", dvb0, 1);
    end
    enb = 1'b0;
    tick();
    chk("idle_vld", dvb0, 0);

    // Byte enables and read-first on A
    ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'hAABB_CCDD;
    tick();
    chk("be_rdfirst0", douta0, 0);
    chk("be_dva0", dva0, 1);
    wea = 4'b0101; dina = 32'h1122_3344;
    tick();
    chk("be_rdfirst1", douta0, 32'hAABB_CCDD);
    ena = 1'b0; wea = 4'h0; enb = 1'b1; addrb = 4'd3;
    tick();
    enb = 1'b0;
    chk("be_merge", doutb0, 32'hAA22_CC44);

    // Collision: A read-first, B forwarded merge
    ena = 1'b1; wea = 4'hF; addra = 4'd5; dina = 32'h1234_5678;
    tick();
    wea = 4'b1100; dina = 32'hCAFE_0000; enb = 1'b1; addrb = 4'd5;
    tick();
    chk("col_douta", douta0, 32'h1234_5678);
    chk("col_doutb", doutb0, 32'hCAFE_5678);
    chk("col_dvb0", dvb0, 1);
    chk("col_dvb1_early", dvb1, 0);
    ena = 1'b0; wea = 4'h0; enb = 1'b0;
    tick();
    chk("col_douta_r", douta1, 32'h1234_5678);
    chk("col_doutb_r", doutb1, 32'hCAFE_5678);
    chk("col_dvb1", dvb1, 1);
    chk("col_hold_doutb0", doutb0, 32'hCAFE_5678);
    chk("col_hold_dva0", dva0, 0);
    ena = 1'b1; addra = 4'd5;
    tick();
    ena = 1'b0;
    chk("col_after", douta0, 32'hCAFE_5678);

    // Latency of a single B read on both output configurations
    ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h0BAD_F00D;
    tick();
    ena = 1'b0; wea = 4'h0;
    tick();
    enb = 1'b1; addrb = 4'd2;
    tick();
    enb = 1'b0;
    chk("lat_t1_doutb0", doutb0, 32'h0BAD_F00D);
    chk("lat_t1_dvb0", dvb0, 1);
    chk("lat_t1_dvb1", dvb1, 0);
    tick();
    chk("lat_t2_dvb0", dvb0, 0);
    chk("lat_t2_doutb1", doutb1, 32'h0BAD_F00D);
    chk("lat_t2_dvb1", dvb1, 1);
    tick();
    chk("lat_t3_dvb1", dvb1, 0);

    // Reset from RUN, requests while busy, restart mid-clear
    ena = 1'b1; wea = 4'hF; addra = 4'd0; dina = 32'hDEAD_BEEF; enb = 1'b1; addrb = 4'd0;
    rst = 1'b1;
    tick();
    chk("run_rst_doutb0", doutb0, 0);
    chk("run_rst_doutb1", doutb1, 0);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("busy_no_vld", 64'(dva0 | dvb0 | dva1 | dvb1), 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n, seen);
    ena = 1'b0; enb = 1'b0; wea = 4'h0;
    chk("reclr_len", 64'(n), 16);
    chk("reclr_no_strobe", 64'(seen), 0);
    enb = 1'b1; addrb = 4'd0;
    tick();
    enb = 1'b0;
    chk("reclr_mem0", doutb0, 0);
    chk("reclr_vld", dvb0, 1);

    // Wide instance, no clear on reset
    ena2 = 1'b1; wea2 = 8'hFF; addra2 = 10'd1; dina2 = 64'h0123_4567_89AB_CDEF;
    tick();
    addra2 = 10'd1023; dina2 = 64'h0;
    tick();
    wea2 = 8'h80; dina2 = 64'hFF00_0000_0000_0000;
    tick();
    chk("w_rdfirst", douta2, 0);
    wea2 = 8'h00;
    tick();
    ena2 = 1'b0;
    chk("w_msb_lane", douta2, 64'hFF00_0000_0000_0000);
    chk("w_dva", dva2, 1);
    rst2 = 1'b1;
    tick();
    chk("w_rst_busy", busy2, 0);
    chk("w_rst_douta", douta2, 0);
    rst2 = 1'b0; enb2 = 1'b1; addrb2 = 10'd1;
    tick();
    chk("w_survive", doutb2, 64'h0123_4567_89AB_CDEF);
    chk("w_dvb", dvb2, 1);
    ena2 = 1'b1; addra2 = 10'd1023; addrb2 = 10'd1023;
    tick();
    ena2 = 1'b0; enb2 = 1'b0;
    chk("w_same_a", douta2, 64'hFF00_0000_0000_0000);
    chk("w_same_b", doutb2, 64'hFF00_0000_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
